// File: rtl/seq2_pkg.sv
// seq2_pkg: shared MODE, state and direction encodings for the seq2 sequencer.
package seq2_pkg;
  typedef enum logic [1:0] {
    MODE_ONESHOT     = 2'd0,
    MODE_LOOP        = 2'd1,
    MODE_PINGPONG    = 2'd2,
    MODE_ONESHOT_ALT = 2'd3
  } mode_e;
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
endpackage

// File: rtl/seq2_tmr.sv
// seq2_tmr: per-step duration countdown.
// Ports: clk, rstx (sync active-low), load (take val), hold (freeze), val (duration), expire (count is 0).
module seq2_tmr #(
  parameter int BW_TIMEOUT = 3
) (
  input  logic                  clk,
  input  logic                  rstx,
  input  logic                  load,
  input  logic                  hold,
  input  logic [BW_TIMEOUT-1:0] val,
  output logic                  expire
);
  logic [BW_TIMEOUT-1:0] cnt_d, cnt_q;
  always_comb cnt_d = load ? val : (hold || cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
  always_ff @(posedge clk) cnt_q <= !rstx ? '0 : cnt_d;
  assign expire = cnt_q == '0;
endmodule

// File: rtl/seq2.sv
// seq2: table-driven pattern sequencer with one-shot, loop and ping-pong modes.
// Ports: CLK, RSTX (sync active-low), CLR (abort), START/MODE/LAST (run request),
// HOLD (freeze), PTN (pattern/duration table), SEQ/STEP (current entry), BUSY, DONE, WRAP.
module seq2
  import seq2_pkg::*;
#(
  parameter int               BW_SEQ     = 6,
  parameter int               SEQ_CNT    = 6,
  parameter int               BW_SEQ_CNT = 3,
  parameter int               BW_TIMEOUT = 3,
  parameter logic [BW_SEQ-1:0] RV        = 6'b000001
) (
  input  logic                                   CLK,
  input  logic                                   RSTX,
  input  logic                                   CLR,
  input  logic                                   START,
  input  logic [1:0]                             MODE,
  input  logic                                   HOLD,
  input  logic [BW_SEQ_CNT-1:0]                  LAST,
  input  logic [SEQ_CNT*(BW_SEQ+BW_TIMEOUT)-1:0] PTN,
  output logic [BW_SEQ-1:0]                      SEQ,
  output logic [BW_SEQ_CNT-1:0]                  STEP,
  output logic                                   BUSY,
  output logic                                   DONE,
  output logic                                   WRAP
);
  localparam int EW = BW_SEQ + BW_TIMEOUT;
  state_e                state_d, state_q;
  mode_e                 mode_d, mode_q;
  dir_e                  dir_d, dir_q, dir_n;
  logic [BW_SEQ_CNT-1:0] step_d, step_q, last_d, last_q, last_c, nxt, idx;
  logic [BW_SEQ-1:0]     seq_d, seq_q;
  logic                  done_d, done_q, wrap_d, wrap_q;
  logic                  ld, expire, fin;
  logic [EW-1:0]         ent;
  seq2_tmr #(.BW_TIMEOUT(BW_TIMEOUT)) u_tmr (
    .clk   (CLK),
    .rstx  (RSTX),
    .load  (ld),
    .hold  (HOLD),
    .val   (ent[BW_TIMEOUT-1:0]),
    .expire(expire)
  );
  always_comb begin
    fin    = (mode_q == MODE_ONESHOT || mode_q == MODE_ONESHOT_ALT) && step_q == last_q;
    last_c = int'(LAST) >= SEQ_CNT ? BW_SEQ_CNT'(SEQ_CNT - 1) : LAST;
    dir_n  = dir_q;
    nxt    = step_q == last_q ? '0 : step_q + 1'b1;
    // ping-pong bounces off LAST and 0; with LAST=0 it degenerates to repeating step 0
    if (mode_q == MODE_PINGPONG && last_q != '0) begin
      nxt   = (dir_q == DIR_UP && step_q != last_q) ? step_q + 1'b1 : step_q - 1'b1;
      dir_n = nxt == '0 ? DIR_UP : step_q == last_q ? DIR_DOWN : dir_q;
    end
    // table entry of the step about to be entered; PTN is sampled only on entry
    idx     = state_q == S_RUN ? nxt : '0;
    ent     = PTN[(SEQ_CNT - 1 - int'(idx)) * EW +: EW];
    state_d = state_q;
    step_d  = step_q;
    seq_d   = seq_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    last_d  = last_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    ld      = 1'b0;
    if (state_q == S_IDLE) begin
      if (START && !CLR) begin
        state_d = S_RUN;
        step_d  = '0;
        seq_d   = ent[EW-1 -: BW_SEQ];
        dir_d   = DIR_UP;
        mode_d  = mode_e'(MODE);
        last_d  = last_c;
        ld      = 1'b1;
      end
    end else if (CLR) begin
      state_d = S_IDLE;
      step_d  = '0;
      seq_d   = RV;
    end else if (!HOLD && expire) begin
      if (fin) begin
        state_d = S_IDLE;
        step_d  = '0;
        seq_d   = RV;
        done_d  = 1'b1;
      end else begin
        step_d = nxt;
        seq_d  = ent[EW-1 -: BW_SEQ];
        dir_d  = dir_n;
        wrap_d = nxt == '0;
        ld     = 1'b1;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (!RSTX) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      seq_q   <= RV;
      dir_q   <= DIR_UP;
      mode_q  <= MODE_ONESHOT;
      last_q  <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      seq_q   <= seq_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end
  assign SEQ  = seq_q;
  assign STEP = step_q;
  assign BUSY = state_q == S_RUN;
  assign DONE = done_q;
  assign WRAP = wrap_q;
endmodule

// File: tb/tb_seq2.sv
// tb_seq2: scoreboard bench for seq2 with directed vectors.
module tb_seq2;
  logic        CLK = 1'b0;
  logic        RSTX, CLR, START, HOLD;
  logic [1:0]  MODE;
  logic [2:0]  LAST;
  logic [53:0] PTN;
  logic [5:0]  SEQ;
  logic [2:0]  STEP;
  logic        BUSY, DONE, WRAP;
  typedef struct {
    int         cyc;
    logic [5:0] seq;
    logic [2:0] step;
    logic       busy, done, wrap;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  seq2 dut (
    .CLK(CLK), .RSTX(RSTX), .CLR(CLR), .START(START), .MODE(MODE), .HOLD(HOLD),
    .LAST(LAST), .PTN(PTN), .SEQ(SEQ), .STEP(STEP), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_tests++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL stale cyc%0d: expectation for cyc%0d never compared", cyc, e.cyc);
      end else if ({SEQ, STEP, BUSY, DONE, WRAP} !== {e.seq, e.step, e.busy, e.done, e.wrap}) begin
        n_fail++;
        $display("FAIL cyc%0d: got seq=%b step=%0d busy=%b done=%b wrap=%b, want seq=%b step=%0d busy=%b done=%b wrap=%b",
                 cyc, SEQ, STEP, BUSY, DONE, WRAP, e.seq, e.step, e.busy, e.done, e.wrap);
      end
    end
  end
  task automatic tick(input logic [5:0] s, input logic [2:0] st, input logic b, input logic d, input logic w);
    q.push_back('{cyc + 1, s, st, b, d, w});
    @(posedge CLK);
    #1;
    START = 1'b0;
    CLR   = 1'b0;
  endtask
  task automatic step(input int s, input int n, input logic w);
    for (int k = 0; k < n; k++) tick(6'(1 << s), 3'(s), 1'b1, 1'b0, w && k == 0);
  endtask
  task automatic idle(input logic d);
    tick(6'b000001, 3'd0, 1'b0, d, 1'b0);
  endtask
  task automatic go(input logic [1:0] m, input logic [2:0] l);
    START = 1'b1;
    MODE  = m;
    LAST  = l;
  endtask
  initial begin
    for (int i = 0; i < 6; i++) PTN[(5 - i) * 9 +: 9] = {6'(1 << i), 3'(i)};
    RSTX = 1'b0; CLR = 1'b0; START = 1'b0; HOLD = 1'b0; MODE = 2'd0; LAST = 3'd0;
    idle(1'b0); idle(1'b0);
    RSTX = 1'b1;
    idle(1'b0);
    go(2'd0, 3'd5);
    step(0, 1, 1'b0);
    go(2'd2, 3'd1);
    for (int s = 1; s < 6; s++) step(s, s + 1, 1'b0);
    idle(1'b1); idle(1'b0);
    go(2'd1, 3'd2);
    for (int p = 0; p < 3; p++) begin
      step(0, 1, p > 0);
      if (p < 2) begin
        step(1, 2, 1'b0);
        step(2, 3, 1'b0);
      end
    end
    CLR = 1'b1;
    idle(1'b0);
    go(2'd2, 3'd2);
    step(0, 1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      step(1, 2, 1'b0);
      step(2, 3, 1'b0);
      step(1, 2, 1'b0);
      step(0, 1, 1'b1);
    end
    CLR = 1'b1;
    idle(1'b0);
    go(2'd1, 3'd0);
    step(0, 1, 1'b0);
    repeat (3) step(0, 1, 1'b1);
    CLR = 1'b1;
    idle(1'b0);
    go(2'd0, 3'd5);
    for (int s = 0; s < 3; s++) step(s, s + 1, 1'b0);
    step(3, 2, 1'b0);
    HOLD = 1'b1;
    step(3, 4, 1'b0);
    HOLD = 1'b0;
    step(3, 2, 1'b0);
    CLR = 1'b1; START = 1'b1;
    idle(1'b0); idle(1'b0);
    go(2'd0, 3'd7);
    for (int s = 0; s < 6; s++) step(s, s + 1, 1'b0);
    idle(1'b1); idle(1'b0);
    go(2'd0, 3'd5);
    step(0, 1, 1'b0);
    step(1, 2, 1'b0);
    RSTX = 1'b0;
    idle(1'b0); idle(1'b0);
    RSTX = 1'b1;
    idle(1'b0);
    @(negedge CLK);
    @(negedge CLK);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq2.md
SEQ2 -- requirements
Module: seq2

Interface
REQ-001 SHALL have parameter BW_SEQ, default 6: width of each output pattern.
REQ-002 SHALL have parameter SEQ_CNT, default 6: number of table entries, 2..(2**BW_SEQ_CNT).
REQ-003 SHALL have parameter BW_SEQ_CNT, default 3: width of step indices.
REQ-004 SHALL have parameter BW_TIMEOUT, default 3: width of each per-step duration field.
REQ-005 SHALL have parameter RV, default 6'b000001: SEQ value when idle and after reset.
REQ-006 SHALL have port CLK, input, 1: the single clock; all logic rises on CLK.
REQ-007 SHALL have port RSTX, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port CLR, input, 1: synchronous abort to idle.
REQ-009 SHALL have port START, input, 1: run request, sampled in idle only.
REQ-010 SHALL have port MODE, input, 2: 0 one-shot, 1 loop, 2 ping-pong, 3 treated as one-shot; sampled with START.
REQ-011 SHALL have port HOLD, input, 1: freezes a running sequence.
REQ-012 SHALL have port LAST, input, BW_SEQ_CNT: last active step index, sampled with START.
REQ-013 SHALL have port PTN, input, SEQ_CNT*(BW_SEQ+BW_TIMEOUT): entry i = {pattern_i, dur_i}; entry 0 occupies the MSBs.
REQ-014 SHALL have port SEQ, output, BW_SEQ: current pattern, registered.
REQ-015 SHALL have port STEP, output, BW_SEQ_CNT: current step index, registered.
REQ-016 SHALL have port BUSY, output, 1: high while running.
REQ-017 SHALL have port DONE, output, 1: one-cycle pulse at one-shot completion.
REQ-018 SHALL have port WRAP, output, 1: one-cycle pulse each time step 0 is re-entered in loop or ping-pong mode.

Function
REQ-019 SHALL implement states IDLE and RUN, plus a direction flag DIR (up/down) used only in ping-pong mode.
REQ-020 SHALL, in IDLE with START=1, enter RUN on the next edge with STEP=0, SEQ=pattern_0, BUSY=1 and DIR=up, latching MODE and LAST.
REQ-021 SHALL hold step i for dur_i+1 cycles; dur_i=0 gives one cycle.
REQ-022 SHALL clamp a latched LAST >= SEQ_CNT to SEQ_CNT-1.
REQ-023 SHALL, in one-shot mode after the last cycle of step LAST, return to IDLE with SEQ=RV, STEP=0, BUSY=0, and DONE=1 for exactly that first idle cycle.
REQ-024 SHALL, in loop mode, follow step LAST with step 0 and assert WRAP in the first cycle of step 0.
REQ-025 SHALL, in ping-pong mode, visit steps 0..LAST..0 without repeating endpoints, reversing DIR at LAST and at 0, and assert WRAP on re-entry to step 0.
REQ-026 SHALL, when LAST=0 in loop or ping-pong mode, repeat step 0 indefinitely with WRAP pulsing every dur_0+1 cycles.
REQ-027 SHALL, with HOLD=1 in RUN, freeze the duration counter, STEP, SEQ and DIR, and suppress new WRAP/DONE pulses; HOLD in IDLE has no effect.
REQ-028 SHALL ignore START while in RUN; MODE, LAST and PTN changes mid-run SHALL NOT affect the latched MODE and LAST.
REQ-029 SHALL sample PTN fields on step entry, so a changed PTN takes effect only at the next step transition.
REQ-030 SHALL give CLR priority over START and HOLD: next state IDLE, SEQ=RV, STEP=0, BUSY=0, no DONE pulse.

Reset
REQ-031 SHALL, on the CLK edge with RSTX=0, set state=IDLE, SEQ=RV, STEP=0, BUSY=0, DONE=0, WRAP=0, DIR=up and the duration counter to 0; reset overrides all other inputs.

Structure
REQ-032 SHALL place the MODE encodings and state encodings in a shared package/include, seq2_pkg.
REQ-033 SHALL implement the per-step duration countdown (load, hold, expire) as sub-module seq2_tmr, parameterised by BW_TIMEOUT.

Verification (default parameters; PTN = one-hot patterns 000001..100000 with dur 0..5)
REQ-034 SHALL check reset: RSTX=0 for 2 cycles mid-run -> SEQ=000001, BUSY=0, STEP=0, DONE=0 on the following edge.
REQ-035 SHALL check one-shot, LAST=5: START -> patterns held for 1,2,3,4,5,6 cycles; BUSY high for 21 cycles; then DONE=1 for 1 cycle with SEQ=000001.
REQ-036 SHALL check loop, LAST=2: period of 6 cycles (000001 x1, 000010 x2, 000100 x3), with WRAP every 6 cycles starting from the second pass.
REQ-037 SHALL check ping-pong, LAST=2: STEP sequence 0,1,2,1,0,1 with durations 1,2,3,2,1,2 cycles, and WRAP on each return to step 0.
REQ-038 SHALL check HOLD=1 for 4 cycles during step 3: step 3 lasts 8 cycles; then CLR and START in the same cycle -> IDLE, no DONE.
REQ-039 SHALL check LAST=7 in one-shot mode: clamped to 5, giving the same 21-cycle run as REQ-035.
